regfile_sb: RTL

Parametrised general-purpose register file for the pipelined RV32I core, replacing the fixed 32x32 two-read-port file. It adds configurable width, depth and read-port count, a per-register busy scoreboard for hazard detection, optional same-cycle write-to-read bypass, and a post-reset sweep FSM. The sweep zeroes the array one entry per cycle, so the storage can map to RAM instead of flops. It sits between decode (read and issue) and writeback (write).

---
 rtl/regfile_sb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with busy scoreboard and post-reset
// init sweep for the pipelined RV32I core.
//
// Parameters
//   XLEN  data width
//   NREG  number of registers (power of two, >= 2)
//   NRD   number of read ports (1..4)
//   AW    address width, derived from NREG; do not override
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   ready           high once the init sweep has zeroed every entry
//   we, wa, wd      writeback write port
//   iss_v, iss_rd   issue strobe; marks iss_rd busy
//   ra              packed read addresses, port k at [k*AW +: AW]
//   rdata           packed read data, port k at [k*XLEN +: XLEN] (combinational)
//   rbusy           per-port busy flag (combinational)
//
// Build option
//   RF_BYPASS_EN    when defined, a same-cycle write is forwarded to matching
//                   read ports (write-first); otherwise reads are read-first.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_v,
  input  logic [AW-1:0]       iss_rd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [AW-1:0] LastPtr = AW'(NREG - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ready_q, ready_d;
  logic [NREG-1:0] busy_q, busy_d;

  // Storage has no reset so it can map onto a RAM; the sweep zeroes it.
  logic [XLEN-1:0] rf_q [NREG];

  logic            run;
  logic            wr_hit;
  logic            iss_hit;
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [AW-1:0]   rd_addr;

  assign run     = (state_q == StRun);
  // Reset blocks all architectural updates in its cycle.
  assign wr_hit  = run && !rst && we && (wa != '0);
  assign iss_hit = run && !rst && iss_v && (iss_rd != '0);

  // Sweep control
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    unique case (state_q)
      StInit: begin
        if (ptr_q == LastPtr) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      StRun: begin
      end
      default: state_d = StInit;
    endcase
  end

  // Scoreboard: issue set is applied after write clear so the newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit) begin
      busy_d[wa] = 1'b0;
    end
    if (iss_hit) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Single array write port shared between the sweep and writeback.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = ptr_q;
    rf_wd = '0;
    if (!rst) begin
      if (!run) begin
        rf_we = 1'b1;
      end else if (wr_hit) begin
        rf_we = 1'b1;
        rf_wa = wa;
        rf_wd = wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  assign ready = ready_q;

  // Read ports: zero during the sweep and for x0.
  always_comb begin
    rdata   = '0;
    rbusy   = '0;
    rd_addr = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_addr = ra[k*AW +: AW];
      if (run && (rd_addr != '0)) begin
`ifdef RF_BYPASS_EN
        if (wr_hit && (wa == rd_addr)) begin
          rdata[k*XLEN +: XLEN] = wd;
          rbusy[k]              = 1'b0;
        end else begin
          rdata[k*XLEN +: XLEN] = rf_q[rd_addr];
          rbusy[k]              = busy_q[rd_addr];
        end
`else
        rdata[k*XLEN +: XLEN] = rf_q[rd_addr];
        rbusy[k]              = busy_q[rd_addr];
`endif
      end
    end
  end

endmodule
